// File: rtl/amba4_pkg.sv
// Shared AMBA4 AXI types, encodings and small helpers used by the burst logic.
package amba4_pkg;

    // Field types for the AXI address channels.
    typedef logic [7:0] LEN_T;
    typedef logic [2:0] SIZE_T;
    typedef logic [1:0] BURST_T;
    typedef logic [1:0] RESP_T;

    // AXBURST encodings.
    localparam BURST_T BURST_FIXED = 2'b00;
    localparam BURST_T BURST_INCR  = 2'b01;
    localparam BURST_T BURST_WRAP  = 2'b10;
    localparam BURST_T BURST_RSVD  = 2'b11;

    // xRESP encodings.
    localparam RESP_T RESP_OKAY   = 2'b00;
    localparam RESP_T RESP_EXOKAY = 2'b01;
    localparam RESP_T RESP_SLVERR = 2'b10;
    localparam RESP_T RESP_DECERR = 2'b11;

    // A legal wrap burst spans at most 16 beats of 128 bytes, so 12 bits of mask suffice.
    localparam int unsigned WRAP_MASK_W = 12;
    // Wide enough for (255+1) << 7 so the intermediate never overflows.
    localparam int unsigned WRAP_TOTAL_W = 20;

    // Byte mask of the wrap container: ((len+1) << size) - 1.
    function automatic logic [WRAP_MASK_W-1:0] wrap_mask(input LEN_T len, input SIZE_T size);
        logic [WRAP_TOTAL_W-1:0] total;
        total = (WRAP_TOTAL_W'(len) + WRAP_TOTAL_W'(1)) << size;
        return WRAP_MASK_W'(total - WRAP_TOTAL_W'(1));
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Expands an AXI4 AW/AR command into one address per beat (FIXED/INCR/WRAP),
// flagging illegal commands while still emitting len+1 beats.
module axi4_burst_addr_gen
    import amba4_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned DATA_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  LEN_T              cmd_len,
    input  SIZE_T             cmd_size,
    input  BURST_T            cmd_burst,

    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ID_W-1:0]   beat_id,
    output logic [ADDR_W-1:0] beat_addr,
    output LEN_T              beat_idx,
    output logic              beat_last,
    output logic              beat_err
);

    // Largest AXSIZE the data bus can carry.
    localparam int unsigned MAX_SIZE = $clog2(DATA_BYTES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                cmd_acc;
    logic                beat_hs;
    logic                cmd_err;
    logic [ADDR_W-1:0]   cmd_size_mask;

    LEN_T                len_q;
    SIZE_T               size_q;
    BURST_T              burst_q;
    logic [ADDR_W-1:0]   wmask_q;

    logic [ADDR_W-1:0]   beat_bytes;
    logic [ADDR_W-1:0]   incr_base;
    logic [ADDR_W-1:0]   wrap_sum;
    logic [ADDR_W-1:0]   next_addr;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign beat_hs = beat_valid && beat_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a last-beat handshake retires the burst unless a new command chains in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_hs && beat_last && !cmd_acc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs: a new command may be taken in the same cycle the last beat leaves.
    always_comb begin
        beat_valid = 1'b0;
        cmd_ready  = 1'b0;
        beat_valid = (state_q == ST_BURST);
        cmd_ready  = (state_q == ST_IDLE) || (beat_valid && beat_ready && beat_last);
    end

    // Legality of the incoming command.
    always_comb begin
        cmd_err       = 1'b0;
        cmd_size_mask = ADDR_W'((32'd1 << cmd_size) - 32'd1);
        if (cmd_burst == BURST_RSVD) begin
            cmd_err = 1'b1;
        end
        if (32'(cmd_size) > MAX_SIZE) begin
            cmd_err = 1'b1;
        end
        if (cmd_burst == BURST_WRAP) begin
            if (!((cmd_len == LEN_T'(1)) || (cmd_len == LEN_T'(3)) ||
                  (cmd_len == LEN_T'(7)) || (cmd_len == LEN_T'(15)))) begin
                cmd_err = 1'b1;
            end
            if ((cmd_addr & cmd_size_mask) != '0) begin
                cmd_err = 1'b1;
            end
        end
    end

    // Address of the following beat; FIXED and erroneous bursts hold the command address.
    always_comb begin
        beat_bytes = ADDR_W'(32'd1 << size_q);
        incr_base  = beat_addr & ~(beat_bytes - ADDR_W'(1));
        wrap_sum   = beat_addr + beat_bytes;
        next_addr  = beat_addr;
        if (!beat_err) begin
            case (burst_q)
                BURST_INCR: next_addr = incr_base + beat_bytes;
                BURST_WRAP: next_addr = (beat_addr & ~wmask_q) | (wrap_sum & wmask_q);
                default:    next_addr = beat_addr;
            endcase
        end
    end

    // Beat payload: loaded with beat 0 on accept, advanced on every beat handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_id   <= '0;
            beat_addr <= '0;
            beat_idx  <= '0;
            beat_last <= 1'b0;
            beat_err  <= 1'b0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            wmask_q   <= '0;
        end else if (cmd_acc) begin
            beat_id   <= cmd_id;
            beat_addr <= cmd_addr;
            beat_idx  <= '0;
            beat_last <= (cmd_len == LEN_T'(0));
            beat_err  <= cmd_err;
            len_q     <= cmd_len;
            size_q    <= cmd_size;
            burst_q   <= cmd_burst;
            wmask_q   <= ADDR_W'(wrap_mask(cmd_len, cmd_size));
        end else if (beat_hs) begin
            beat_idx  <= beat_idx + LEN_T'(1);
            beat_addr <= next_addr;
            beat_last <= ((beat_idx + LEN_T'(1)) == len_q);
        end
    end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Bench for axi4_burst_addr_gen: directed cases plus random commands against an arithmetic model.
module tb_axi4_burst_addr_gen;
    import amba4_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned DATA_BYTES = 8;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    LEN_T              cmd_len;
    SIZE_T             cmd_size;
    BURST_T            cmd_burst;
    logic              beat_valid;
    logic              beat_ready;
    logic [ID_W-1:0]   beat_id;
    logic [ADDR_W-1:0] beat_addr;
    LEN_T              beat_idx;
    logic              beat_last;
    logic              beat_err;

    int n_tests = 0;
    int n_fail  = 0;

    axi4_burst_addr_gen #(
        .ADDR_W(ADDR_W),
        .ID_W(ID_W),
        .DATA_BYTES(DATA_BYTES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_id(cmd_id),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_size(cmd_size),
        .cmd_burst(cmd_burst),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_id(beat_id),
        .beat_addr(beat_addr),
        .beat_idx(beat_idx),
        .beat_last(beat_last),
        .beat_err(beat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: legality from the AXI rules.
    function automatic bit exp_err(input cmd_t c);
        if (c.burst == 2'b11) return 1'b1;
        if (int'(c.size) > $clog2(DATA_BYTES)) return 1'b1;
        if (c.burst == 2'b10) begin
            if (!(c.len == 8'd1 || c.len == 8'd3 || c.len == 8'd7 || c.len == 8'd15)) return 1'b1;
            if ((longint'(c.addr) % (longint'(1) << c.size)) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference: address of beat n computed directly from the burst formulas.
    function automatic logic [31:0] exp_addr(input cmd_t c, input int n);
        longint a, bytes, total, base;
        a     = longint'(c.addr);
        bytes = longint'(1) << c.size;
        if (n == 0 || exp_err(c) || c.burst == 2'b00) return c.addr;
        if (c.burst == 2'b01) return 32'((a / bytes) * bytes + longint'(n) * bytes);
        total = (longint'(c.len) + 1) * bytes;
        base  = (a / total) * total;
        return 32'(base + ((a - base) + longint'(n) * bytes) % total);
    endfunction

    task automatic present(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_id    = c.id;
        cmd_addr  = c.addr;
        cmd_len   = c.len;
        cmd_size  = c.size;
        cmd_burst = c.burst;
    endtask

    task automatic check_beat(input cmd_t c, input int n, input string tag);
        check({tag, "_valid"}, 64'(beat_valid), 64'(1));
        check({tag, "_id"},    64'(beat_id),    64'(c.id));
        check({tag, "_addr"},  64'(beat_addr),  64'(exp_addr(c, n)));
        check({tag, "_idx"},   64'(beat_idx),   64'(n));
        check({tag, "_last"},  64'(beat_last),  64'(n == int'(c.len)));
        check({tag, "_err"},   64'(beat_err),   64'(exp_err(c)));
    endtask

    // Runs one burst; stall_mode 0 none, 1 one stall per beat, 2 random stalls.
    // With chain set, nc is presented during the last beat of c.
    task automatic do_burst(input cmd_t c, input int stall_mode, input bit started,
                            input bit chain, input cmd_t nc);
        int stalls;
        if (!started) begin
            present(c);
            #1;
            check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        for (int n = 0; n <= int'(c.len); n++) begin
            stalls = (stall_mode == 1) ? 1 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < stalls; s++) begin
                beat_ready = 1'b0;
                #1;
                check_beat(c, n, "stall");
                check("cmd_ready_stall", 64'(cmd_ready), 64'(0));
                @(posedge clk);
                @(negedge clk);
            end
            beat_ready = 1'b1;
            if (n == int'(c.len) && chain) present(nc);
            #1;
            check_beat(c, n, "beat");
            check("cmd_ready_beat", 64'(cmd_ready), 64'(n == int'(c.len)));
            @(posedge clk);
            @(negedge clk);
            beat_ready = 1'b0;
            cmd_valid  = 1'b0;
        end
        if (!chain) begin
            #1;
            check("valid_after", 64'(beat_valid), 64'(0));
            check("cmd_ready_after", 64'(cmd_ready), 64'(1));
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.id    = 4'($urandom);
        c.addr  = $urandom;
        c.burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        c.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        if (c.burst == 2'b10 && $urandom_range(0, 4) != 0) begin
            c.len  = 8'((2 << $urandom_range(0, 3)) - 1);
            c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
        end else begin
            c.len = 8'($urandom_range(0, 15));
        end
        return c;
    endfunction

    cmd_t c0, c1, none;
    cmd_t rq[40];
    bit   chain_q[40];

    initial begin
        none       = '0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_id     = '0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        beat_ready = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(beat_valid), 64'(0));
        check("rst_addr",  64'(beat_addr),  64'(0));
        check("rst_idx",   64'(beat_idx),   64'(0));
        check("rst_id",    64'(beat_id),    64'(0));
        check("rst_last",  64'(beat_last),  64'(0));
        check("rst_err",   64'(beat_err),   64'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);

        // INCR, unaligned start.
        c0 = '{id: 4'h1, addr: 32'h1003, len: 8'd3, size: 3'd2, burst: 2'b01};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        // WRAP crossing the container boundary.
        c0 = '{id: 4'h2, addr: 32'h38, len: 8'd3, size: 3'd3, burst: 2'b10};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        // FIXED with ready toggling.
        c0 = '{id: 4'h3, addr: 32'h200, len: 8'd2, size: 3'd2, burst: 2'b00};
        do_burst(c0, 1, 1'b0, 1'b0, none);
        @(negedge clk);
        // Back-to-back, second command during the last beat of the first.
        c0 = '{id: 4'h4, addr: 32'h100, len: 8'd1, size: 3'd3, burst: 2'b01};
        c1 = '{id: 4'h5, addr: 32'h38,  len: 8'd3, size: 3'd3, burst: 2'b10};
        do_burst(c0, 0, 1'b0, 1'b1, c1);
        do_burst(c1, 0, 1'b1, 1'b0, none);
        @(negedge clk);
        // Error cases.
        c0 = '{id: 4'h6, addr: 32'h84, len: 8'd1, size: 3'd2, burst: 2'b11};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        c0 = '{id: 4'h7, addr: 32'h40, len: 8'd2, size: 3'd2, burst: 2'b10};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        c0 = '{id: 4'h8, addr: 32'h80, len: 8'd1, size: 3'd4, burst: 2'b01};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        c0 = '{id: 4'h9, addr: 32'h42, len: 8'd3, size: 3'd2, burst: 2'b10};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);
        // INCR rolling over the top of the address space.
        c0 = '{id: 4'hA, addr: 32'hFFFF_FFF9, len: 8'd3, size: 3'd3, burst: 2'b01};
        do_burst(c0, 2, 1'b0, 1'b0, none);
        @(negedge clk);
        // Maximum length INCR.
        c0 = '{id: 4'hB, addr: 32'h0001_0000, len: 8'd255, size: 3'd0, burst: 2'b01};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);

        // Reset mid-burst at beat 1 of a len=7 INCR.
        c0 = '{id: 4'hC, addr: 32'h4000, len: 8'd7, size: 3'd2, burst: 2'b01};
        present(c0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        beat_ready = 1'b1;
        #1;
        check_beat(c0, 0, "mrst");
        @(posedge clk);
        @(negedge clk);
        beat_ready = 1'b0;
        #1;
        check_beat(c0, 1, "mrst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid", 64'(beat_valid), 64'(0));
        check("mrst_idx",   64'(beat_idx),   64'(0));
        check("mrst_addr",  64'(beat_addr),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        check("mrst_still_idle", 64'(beat_valid), 64'(0));
        c0 = '{id: 4'hD, addr: 32'h5010, len: 8'd2, size: 3'd3, burst: 2'b01};
        do_burst(c0, 0, 1'b0, 1'b0, none);
        @(negedge clk);

        // Random commands, some chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            rq[i]      = rand_cmd();
            chain_q[i] = (i < 39) && ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 40; i++) begin
            do_burst(rq[i], 2, (i > 0) && chain_q[i-1], chain_q[i], (i < 39) ? rq[i+1] : none);
            if (!chain_q[i]) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
